// File: rtl/voice_cmd_classifier.sv
// voice_cmd_classifier: talk-triggered sequencer driving feature extraction and the
// DTW bank, then a sequential best/second-best scan with noise and margin rejection.
module voice_cmd_classifier #(
    parameter int NUM_WORDS = 9,
    parameter int SCORE_W   = 25,
    parameter int IDX_W     = 4,
    parameter int MARGIN    = 0,
    parameter int TIMEOUT   = 2**24
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_talk,
    output logic                         o_feature_start,
    input  logic                         i_feature_done,
    input  logic                         i_training_enable,
    input  logic [IDX_W-1:0]             i_training_select,
    output logic [NUM_WORDS-1:0]         o_dtw_start,
    output logic [NUM_WORDS-1:0]         o_dtw_train,
    input  logic [NUM_WORDS-1:0]         i_dtw_done,
    input  logic [NUM_WORDS*SCORE_W-1:0] i_dtw_score,
    output logic [IDX_W-1:0]             o_cmd_index,
    output logic                         o_cmd_reject,
    output logic                         o_done,
    output logic                         o_timeout_err,
    output logic                         o_busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]     NW       = (IDX_W + 1)'(NUM_WORDS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [SCORE_W-1:0] MARGIN_S = SCORE_W'(MARGIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECORD,
        S_DTW_WAIT,
        S_SCAN,
        S_DECIDE
    } state_t;

    state_t                 r_state;
    logic                   r_talk_q;
    logic                   r_train;
    logic [IDX_W-1:0]       r_sel;
    logic [NUM_WORDS-1:0]   r_mask;
    logic [WD_W-1:0]        r_wd;
    logic [IDX_W-1:0]       r_scan_i;
    logic [IDX_W-1:0]       r_best_idx;
    logic [SCORE_W-1:0]     r_best;
    logic [SCORE_W-1:0]     r_second;
    logic                   r_feature_start;
    logic [NUM_WORDS-1:0]   r_dtw_start;
    logic [NUM_WORDS-1:0]   r_dtw_train;
    logic [IDX_W-1:0]       r_cmd_index;
    logic                   r_cmd_reject;
    logic                   r_done;
    logic                   r_timeout_err;

    logic [SCORE_W-1:0]     w_score;
    logic [NUM_WORDS-1:0]   w_onehot;
    logic                   w_sel_ok;
    logic                   w_all_done;
    logic [SCORE_W-1:0]     w_diff;

    assign w_score    = i_dtw_score[int'(r_scan_i)*SCORE_W +: SCORE_W];
    assign w_onehot   = NUM_WORDS'(1) << i_training_select;
    assign w_sel_ok   = {1'b0, i_training_select} < NW;
    assign w_all_done = (i_dtw_done & r_mask) == r_mask;
    // best never exceeds second, so this cannot wrap
    assign w_diff     = r_second - r_best;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_talk_q        <= 1'b0;
            r_train         <= 1'b0;
            r_sel           <= '0;
            r_mask          <= '0;
            r_wd            <= '0;
            r_scan_i        <= '0;
            r_best_idx      <= '0;
            r_best          <= '0;
            r_second        <= '0;
            r_feature_start <= 1'b0;
            r_dtw_start     <= '0;
            r_dtw_train     <= '0;
            r_cmd_index     <= '0;
            r_cmd_reject    <= 1'b0;
            r_done          <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_talk_q        <= i_talk;
            r_feature_start <= 1'b0;
            r_dtw_start     <= '0;
            r_done          <= 1'b0;
            r_timeout_err   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_wd <= '0;
                    if (i_talk && !r_talk_q) begin
                        r_feature_start <= 1'b1;
                        r_state         <= S_RECORD;
                    end
                end
                S_RECORD: begin
                    if (i_feature_done) begin
                        r_wd <= '0;
                        if (i_training_enable && w_sel_ok) begin
                            r_dtw_start <= w_onehot;
                            r_dtw_train <= w_onehot;
                            r_mask      <= w_onehot;
                            r_train     <= 1'b1;
                            r_sel       <= i_training_select;
                            r_state     <= S_DTW_WAIT;
                        end else if (i_training_enable) begin
                            r_timeout_err <= 1'b1;
                            r_state       <= S_IDLE;
                        end else begin
                            r_dtw_start <= '1;
                            r_mask      <= '1;
                            r_train     <= 1'b0;
                            r_state     <= S_DTW_WAIT;
                        end
                    end else if (r_wd == WD_LAST) begin
                        r_wd          <= '0;
                        r_timeout_err <= 1'b1;
                        r_dtw_train   <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_DTW_WAIT: begin
                    if (w_all_done) begin
                        r_wd <= '0;
                        if (r_train) begin
                            r_done       <= 1'b1;
                            r_cmd_reject <= 1'b1;
                            r_cmd_index  <= r_sel;
                            r_dtw_train  <= '0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_scan_i   <= '0;
                            r_best     <= '1;
                            r_second   <= '1;
                            r_best_idx <= '0;
                            r_state    <= S_SCAN;
                        end
                    end else if (r_wd == WD_LAST) begin
                        r_wd          <= '0;
                        r_timeout_err <= 1'b1;
                        r_dtw_train   <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_score < r_best) begin
                        r_second   <= r_best;
                        r_best     <= w_score;
                        r_best_idx <= r_scan_i;
                    end else if (w_score < r_second) begin
                        r_second <= w_score;
                    end
                    if (r_scan_i == LAST_IDX) begin
                        r_state <= S_DECIDE;
                    end else begin
                        r_scan_i <= r_scan_i + 1'b1;
                    end
                end
                S_DECIDE: begin
                    r_done       <= 1'b1;
                    r_cmd_index  <= r_best_idx;
                    r_cmd_reject <= (r_best_idx == LAST_IDX) ||
                                    ((MARGIN != 0) && (w_diff < MARGIN_S));
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_feature_start = r_feature_start;
    assign o_dtw_start     = r_dtw_start;
    assign o_dtw_train     = r_dtw_train;
    assign o_cmd_index     = r_cmd_index;
    assign o_cmd_reject    = r_cmd_reject;
    assign o_done          = r_done;
    assign o_timeout_err   = r_timeout_err;
    assign o_busy          = (r_state != S_IDLE);

endmodule
